// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage core: forwarding, load-use, memory-wait and multiply stalls.
// Define HAZ_PERF_EN to build the StallCount/FlushCount performance counters.
module hazard_unit_mc #(
  parameter int NSRC    = 2,
  parameter int REGW    = 4,
  parameter int LD_LAT  = 1,
  parameter int MUL_LAT = 1,
  parameter int PC_REG  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*REGW-1:0]   RA_D,
  input  logic [NSRC*REGW-1:0]   RA_E,
  input  logic [REGW-1:0]        WA_E,
  input  logic [REGW-1:0]        WA_M,
  input  logic [REGW-1:0]        WA_W,
  input  logic                   RegWriteE,
  input  logic                   RegWriteM,
  input  logic                   RegWriteW,
  input  logic                   MemtoRegE,
  input  logic                   MemOpM,
  input  logic                   MulStartE,
  input  logic                   BranchTakenE,
  input  logic                   PCWrPendingF,
  input  logic                   PCSrcW,
  output logic                   StallF,
  output logic                   StallD,
  output logic                   StallE,
  output logic                   StallM,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   FlushM,
  output logic                   FlushW,
  output logic [2*NSRC-1:0]      ForwardE,
  output logic                   MemBusy,
  output logic                   MulBusy,
  output logic [15:0]            StallCount,
  output logic [15:0]            FlushCount
);

  localparam int MEMW = $clog2(LD_LAT) + 1;
  localparam int MULW = $clog2(MUL_LAT) + 1;
  localparam logic [MEMW-1:0] MEM_INIT = MEMW'(LD_LAT - 1);
  localparam logic [MULW-1:0] MUL_INIT = MULW'(MUL_LAT - 1);
  localparam logic [REGW-1:0] PC = REGW'(PC_REG);

  logic [MEMW-1:0] memCnt;
  logic [MULW-1:0] mulCnt;
  logic            memStarted;
  logic            mulStarted;
  logic            memLoad;
  logic            mulLoad;
  logic            useHit;
  logic            ldrStall;

  always_comb begin
    ForwardE = '0;
    useHit   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (RA_E[i*REGW +: REGW] == WA_M && RegWriteM &&
          RA_E[i*REGW +: REGW] != PC)
        ForwardE[2*i +: 2] = 2'b10;
      else if (RA_E[i*REGW +: REGW] == WA_W && RegWriteW &&
               RA_E[i*REGW +: REGW] != PC)
        ForwardE[2*i +: 2] = 2'b01;
      if (RA_D[i*REGW +: REGW] == WA_E)
        useHit = 1'b1;
    end
  end

  assign ldrStall = MemtoRegE & RegWriteE & useHit;

  assign MemBusy = (memCnt != '0);
  assign MulBusy = (mulCnt != '0);

  assign StallM = MemBusy;
  assign StallE = MemBusy | MulBusy;
  assign StallD = StallE | ldrStall;
  assign StallF = StallD | PCWrPendingF;
  assign FlushW = MemBusy;
  assign FlushM = MulBusy & ~MemBusy;
  assign FlushE = (ldrStall | BranchTakenE) & ~StallE;
  assign FlushD = PCWrPendingF | PCSrcW | BranchTakenE;

  assign memLoad = MemOpM & ~MemBusy & ~memStarted;
  assign mulLoad = MulStartE & ~MulBusy & ~mulStarted;

  // Started flags keep an op held in its stage from re-arming its counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      memCnt     <= '0;
      memStarted <= 1'b0;
    end else if (memLoad) begin
      memCnt     <= MEM_INIT;
      memStarted <= 1'b1;
    end else if (MemBusy) begin
      memCnt     <= memCnt - MEMW'(1);
    end else begin
      memStarted <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mulCnt     <= '0;
      mulStarted <= 1'b0;
    end else if (mulLoad) begin
      mulCnt     <= MUL_INIT;
      mulStarted <= 1'b1;
    end else begin
      if (MulBusy)
        mulCnt <= mulCnt - MULW'(1);
      if (!StallE)
        mulStarted <= 1'b0;
    end
  end

`ifdef HAZ_PERF_EN
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;
  logic        anyFlush;

  assign anyFlush = FlushD | FlushE | FlushM | FlushW;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallF && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
      if (anyFlush && flushCnt != 16'hFFFF)
        flushCnt <= flushCnt + 16'd1;
    end
  end

  assign StallCount = stallCnt;
  assign FlushCount = flushCnt;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: directed scenarios then random traffic
// checked against a cycle-count reference model.
module tb_hazard_unit_mc;

  localparam int NSRC = 2;
  localparam int REGW = 4;
  localparam int LDL  = 3;
  localparam int MULL = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NSRC*REGW-1:0] RA_D, RA_E;
  logic [REGW-1:0] WA_E, WA_M, WA_W;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic MemtoRegE, MemOpM, MulStartE;
  logic BranchTakenE, PCWrPendingF, PCSrcW;
  logic StallF, StallD, StallE, StallM;
  logic FlushD, FlushE, FlushM, FlushW;
  logic [2*NSRC-1:0] ForwardE;
  logic MemBusy, MulBusy;
  logic [15:0] StallCount, FlushCount;

  int nCompared = 0;
  int nMismatched = 0;

  int memLeft = 0, mulLeft = 0;
  bit memCounted = 0, mulCounted = 0;
  int stallTot = 0, flushTot = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .NSRC(NSRC), .REGW(REGW), .LD_LAT(LDL),
    .MUL_LAT(MULL), .PC_REG(15)
  ) dut (
    .clk(clk), .reset(reset),
    .RA_D(RA_D), .RA_E(RA_E),
    .WA_E(WA_E), .WA_M(WA_M), .WA_W(WA_W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .MemOpM(MemOpM), .MulStartE(MulStartE),
    .BranchTakenE(BranchTakenE),
    .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .FlushW(FlushW),
    .ForwardE(ForwardE),
    .MemBusy(MemBusy), .MulBusy(MulBusy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; RA_D = '0; RA_E = '0;
    WA_E = 0; WA_M = 0; WA_W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemOpM = 0; MulStartE = 0;
    BranchTakenE = 0; PCWrPendingF = 0; PCSrcW = 0;
  endtask

  function automatic int field(input logic [NSRC*REGW-1:0] v,
                               input int i);
    return int'((v >> (i * REGW)) & 8'h0F);
  endfunction

  // Compare all outputs against the model, then advance model one cycle.
  task automatic cycle();
    bit mb, ub, ldr, sE, sD, sF, fD, fE, fM, fW;
    logic [3:0] fwd;
    int expS, expF;
    mb = memLeft > 0;
    ub = mulLeft > 0;
    fwd = '0;
    ldr = 0;
    for (int i = 0; i < NSRC; i++) begin
      int ra;
      ra = field(RA_E, i);
      if (RegWriteM && ra == int'(WA_M) && ra != 15)
        fwd[2*i +: 2] = 2'b10;
      else if (RegWriteW && ra == int'(WA_W) && ra != 15)
        fwd[2*i +: 2] = 2'b01;
      if (field(RA_D, i) == int'(WA_E) && MemtoRegE && RegWriteE)
        ldr = 1;
    end
    sE = mb || ub;
    sD = sE || ldr;
    sF = sD || PCWrPendingF;
    fW = mb;
    fM = ub && !mb;
    fE = (ldr || BranchTakenE) && !sE;
    fD = PCWrPendingF || PCSrcW || BranchTakenE;
`ifdef HAZ_PERF_EN
    expS = stallTot; expF = flushTot;
`else
    expS = 0; expF = 0;
`endif
    check("fwd", 32'(ForwardE), 32'(fwd));
    check("stall", {StallF, StallD, StallE, StallM},
          {sF, sD, sE, mb});
    check("flush", {FlushD, FlushE, FlushM, FlushW},
          {fD, fE, fM, fW});
    check("busy", {MemBusy, MulBusy}, {mb, ub});
    check("perf", {StallCount, FlushCount},
          {expS[15:0], expF[15:0]});
    if (reset) begin
      memLeft = 0; mulLeft = 0;
      memCounted = 0; mulCounted = 0;
      stallTot = 0; flushTot = 0;
    end else begin
      if (sF && stallTot < 65535) stallTot++;
      if ((fD || fE || fM || fW) && flushTot < 65535) flushTot++;
      if (MemOpM && !mb && !memCounted) begin
        memLeft = LDL - 1; memCounted = 1;
      end else if (mb) memLeft--;
      else memCounted = 0;
      if (MulStartE && !ub && !mulCounted) begin
        mulLeft = MULL - 1; mulCounted = 1;
      end else begin
        if (ub) mulLeft--;
        if (!sE) mulCounted = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] pickReg();
    int r;
    r = $urandom_range(0, 5);
    return (r == 5) ? 4'd15 : 4'(r);
  endfunction

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rstIdle", {StallF, StallD, StallE, StallM, FlushD,
          FlushE, FlushM, FlushW, MemBusy, MulBusy, ForwardE}, 0);
    cycle();

    RA_E = 8'h33; WA_M = 3; RegWriteM = 1; WA_W = 3; RegWriteW = 1;
    #1; check("fwdMW", 32'(ForwardE), 32'b1010); cycle();
    RA_E = 8'hFF; WA_M = 15; WA_W = 15;
    #1; check("fwdPc", 32'(ForwardE), 0); cycle();

    idle();
    MemtoRegE = 1; RegWriteE = 1; WA_E = 5; RA_D = 8'h50;
    #1; check("ldUse", {StallF, StallD, FlushE, StallE}, 4'b1110);
    cycle();

    idle(); MemOpM = 1;
    for (int k = 0; k < 4; k++) begin
      bit w;
      w = (k == 1 || k == 2);
      #1;
      check("memWait", {MemBusy, StallF, StallD, StallE, StallM, FlushW},
            {6{w}});
      cycle();
    end

    idle(); MulStartE = 1;
    for (int k = 0; k < 5; k++) begin
      bit w;
      w = (k >= 1 && k <= 3);
      if (k == 4) MulStartE = 0;
      #1; check("mul", {MulBusy, FlushM, StallE}, {3{w}});
      cycle();
    end

    idle(); MulStartE = 1; MemOpM = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle();
      #1;
      if (k == 1) check("ovlFlushM", 32'(FlushM), 0);
      if (k == 3) check("ovlStallE", {StallE, FlushM, MemBusy}, 3'b110);
      cycle();
    end

    idle(); MemOpM = 1;
    for (int k = 0; k < 4; k++) begin
      BranchTakenE = (k == 1 || k == 3);
      #1;
      if (k == 1) check("brWait", {FlushD, FlushE}, 2'b10);
      if (k == 3) check("brAfter", {FlushD, FlushE}, 2'b11);
      cycle();
    end

    idle(); MulStartE = 1;
    for (int k = 0; k < 4; k++) begin
      reset = (k == 2);
      if (k == 3) idle();
      #1;
      if (k == 3)
        check("rstMul", {MulBusy, StallF, StallD, StallE, StallM,
              StallCount}, 0);
      cycle();
    end

    for (int n = 0; n < 3000; n++) begin
      RA_D = {pickReg(), pickReg()};
      RA_E = {pickReg(), pickReg()};
      WA_E = pickReg(); WA_M = pickReg(); WA_W = pickReg();
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      MemOpM = ($urandom_range(0, 4) == 0);
      MulStartE = ($urandom_range(0, 4) == 0);
      BranchTakenE = ($urandom_range(0, 6) == 0);
      PCWrPendingF = ($urandom_range(0, 7) == 0);
      PCSrcW = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 60) == 0);
      #1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCompared, nMismatched);
    $finish;
  end

endmodule
